// File: rtl/scoreboard_pkg.sv
// Shared definitions for the score keeper and the display path it feeds.
package scoreboard_pkg;

    // Score registers are two-digit binary values on an 8-bit bus.
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned MAX_SCORE_DEFAULT = 99;

    // One-level undo history: which score(s) the last accepted action raised.
    typedef enum logic [1:0] {
        LastNone = 2'd0,
        LastP1   = 2'd1,
        LastP2   = 2'd2,
        LastBoth = 2'd3
    } last_action_e;

    // Decrement that stops at zero.
    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] value);
        return (value == '0) ? '0 : value - SCORE_W'(1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> debounce counter -> 1-cycle rising-edge pulse.
// The pulse appears DEBOUNCE_CYCLES+3 edges after the first edge sampling a stable high.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the flip happens on that edge.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Debounce: count consecutive disagreeing cycles, any agreement restarts at 0.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer, debounce state and registered edge pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= level_q & ~level_prev_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = pulse_q;

endmodule

// File: rtl/score_keeper.sv
// Two-player score keeper: debounced point/undo/clear buttons, saturating scores,
// one-level undo history and a change pulse for the display controller.
module score_keeper
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned MAX_SCORE       = MAX_SCORE_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               p1_btn_i,
    input  logic               p2_btn_i,
    input  logic               undo_btn_i,
    input  logic               clear_btn_i,
    output logic [SCORE_W-1:0] p1_score_o,
    output logic [SCORE_W-1:0] p2_score_o,
    output logic [1:0]         last_action_o,
    output logic               score_upd_o
);

    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

    logic p1_ev, p2_ev, undo_ev, clear_ev;
    logic p1_lvl, p2_lvl, undo_lvl, clear_lvl;

    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    last_action_e       last_q, last_d;
    logic               upd_q, upd_d;
    logic               p1_inc, p2_inc;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (p1_btn_i),
        .level_o (p1_lvl),
        .press_o (p1_ev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (p2_btn_i),
        .level_o (p2_lvl),
        .press_o (p2_ev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_undo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (undo_btn_i),
        .level_o (undo_lvl),
        .press_o (undo_ev)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (clear_btn_i),
        .level_o (clear_lvl),
        .press_o (clear_ev)
    );

    // Debounced levels are only needed inside the debouncers.
    logic unused_lvl;
    assign unused_lvl = p1_lvl ^ p2_lvl ^ undo_lvl ^ clear_lvl;

    // Saturated presses leave the score alone and are not recorded as actions.
    assign p1_inc = p1_ev && (p1_q < MAX_VAL);
    assign p2_inc = p2_ev && (p2_q < MAX_VAL);

    // Event resolution, priority clear > undo > points.
    always_comb begin
        p1_d   = p1_q;
        p2_d   = p2_q;
        last_d = last_q;
        if (clear_ev) begin
            p1_d   = '0;
            p2_d   = '0;
            last_d = LastNone;
        end else if (undo_ev) begin
            unique case (last_q)
                LastP1:   p1_d = sat_dec(p1_q);
                LastP2:   p2_d = sat_dec(p2_q);
                LastBoth: begin
                    p1_d = sat_dec(p1_q);
                    p2_d = sat_dec(p2_q);
                end
                default:  ;
            endcase
            last_d = LastNone;
        end else if (p1_ev || p2_ev) begin
            if (p1_inc) p1_d = p1_q + SCORE_W'(1);
            if (p2_inc) p2_d = p2_q + SCORE_W'(1);
            if (p1_inc && p2_inc) begin
                last_d = LastBoth;
            end else if (p1_inc) begin
                last_d = LastP1;
            end else if (p2_inc) begin
                last_d = LastP2;
            end
        end
        upd_d = (p1_d != p1_q) || (p2_d != p2_q);
    end

    // Score, history and change-pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            p1_q   <= '0;
            p2_q   <= '0;
            last_q <= LastNone;
            upd_q  <= 1'b0;
        end else begin
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            last_q <= last_d;
            upd_q  <= upd_d;
        end
    end

    assign p1_score_o    = p1_q;
    assign p2_score_o    = p2_q;
    assign last_action_o = last_q;
    assign score_upd_o   = upd_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: expected score snapshots are queued when a press is driven
// and popped whenever the DUT pulses score_upd_o.
module tb_score_keeper;

    localparam int unsigned DB   = 4;
    localparam int          MAXS = 99;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p1_btn = 1'b0, p2_btn = 1'b0, undo_btn = 1'b0, clear_btn = 1'b0;
    logic [7:0] p1_score, p2_score;
    logic [1:0] last_action;
    logic       score_upd;

    typedef struct {
        int p1;
        int p2;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   upd_cnt = 0;
    int   m_p1 = 0, m_p2 = 0, m_last = 0;

    score_keeper #(.DEBOUNCE_CYCLES(DB), .MAX_SCORE(MAXS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .p1_btn_i     (p1_btn),
        .p2_btn_i     (p2_btn),
        .undo_btn_i   (undo_btn),
        .clear_btn_i  (clear_btn),
        .p1_score_o   (p1_score),
        .p2_score_o   (p2_score),
        .last_action_o(last_action),
        .score_upd_o  (score_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference behaviour for one resolved set of events.
    task automatic model_apply(input bit b1, input bit b2, input bit bu, input bit bc);
        int  o1 = m_p1;
        int  o2 = m_p2;
        bit  i1, i2;
        exp_t e;
        if (bc) begin
            m_p1 = 0; m_p2 = 0; m_last = 0;
        end else if (bu) begin
            if ((m_last == 1 || m_last == 3) && m_p1 > 0) m_p1--;
            if ((m_last == 2 || m_last == 3) && m_p2 > 0) m_p2--;
            m_last = 0;
        end else if (b1 || b2) begin
            i1 = b1 && (m_p1 < MAXS);
            i2 = b2 && (m_p2 < MAXS);
            if (i1) m_p1++;
            if (i2) m_p2++;
            if (i1 && i2) m_last = 3;
            else if (i1) m_last = 1;
            else if (i2) m_last = 2;
        end
        if (m_p1 != o1 || m_p2 != o2) begin
            e.p1 = m_p1; e.p2 = m_p2; e.last = m_last;
            exp_q.push_back(e);
        end
    endtask

    task automatic press(input bit b1, input bit b2, input bit bu, input bit bc,
                         input int hold);
        model_apply(b1, b2, bu, bc);
        @(negedge clk);
        p1_btn = b1; p2_btn = b2; undo_btn = bu; clear_btn = bc;
        repeat (hold) @(negedge clk);
        p1_btn = 0; p2_btn = 0; undo_btn = 0; clear_btn = 0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_p1"}, 32'(p1_score), 32'(m_p1));
        check({tag, "_p2"}, 32'(p2_score), 32'(m_p2));
        check({tag, "_last"}, 32'(last_action), 32'(m_last));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard consumer: every change pulse must match the oldest queued snapshot.
    always @(negedge clk) begin
        if (rst_n && score_upd) begin
            exp_t e;
            upd_cnt++;
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_p1", 32'(p1_score), 32'(e.p1));
                check("sb_p2", 32'(p2_score), 32'(e.p2));
                check("sb_last", 32'(last_action), 32'(e.last));
            end
        end
    end

    initial begin
        int u0;
        repeat (3) @(negedge clk);
        check("rst_p1", 32'(p1_score), 32'd0);
        check("rst_p2", 32'(p2_score), 32'd0);
        check("rst_last", 32'(last_action), 32'd0);
        check("rst_upd", 32'(score_upd), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Timed p1 press held 10 cycles: score changes on edge DB+4 after the press.
        u0 = upd_cnt;
        model_apply(1, 0, 0, 0);
        @(negedge clk);
        p1_btn = 1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) check("timing_e7_p1", 32'(p1_score), 32'd0);
            if (i == 8) begin
                check("timing_e8_p1", 32'(p1_score), 32'd1);
                check("timing_e8_upd", 32'(score_upd), 32'd1);
            end
        end
        repeat (2) @(negedge clk);
        p1_btn = 0;
        repeat (14) @(negedge clk);
        check("timing_pulses", 32'(upd_cnt - u0), 32'd1);
        check_state("timing");

        // Glitchy p2: 2-cycle and 3-cycle highs never reach the debounce count.
        u0 = upd_cnt;
        @(negedge clk);
        p2_btn = 1; repeat (2) @(negedge clk);
        p2_btn = 0; repeat (3) @(negedge clk);
        p2_btn = 1; repeat (3) @(negedge clk);
        p2_btn = 0; repeat (15) @(negedge clk);
        check("glitch_pulses", 32'(upd_cnt - u0), 32'd0);
        check_state("glitch");

        // Reach 5:7, simultaneous point, undo, empty undo.
        repeat (4) press(1, 0, 0, 0, 8);
        repeat (7) press(0, 1, 0, 0, 8);
        check_state("at57");
        press(1, 1, 0, 0, 8);
        check_state("both");
        press(0, 0, 1, 0, 8);
        check_state("undo1");
        u0 = upd_cnt;
        press(0, 0, 1, 0, 8);
        check("undo2_pulses", 32'(upd_cnt - u0), 32'd0);
        check_state("undo2");

        // Clear, then clear again at 0:0 gives no pulse.
        press(0, 0, 0, 1, 8);
        u0 = upd_cnt;
        press(0, 0, 0, 1, 8);
        check("clr00_pulses", 32'(upd_cnt - u0), 32'd0);
        check_state("clr00");

        // Saturation at MAX_SCORE keeps the score and the history.
        repeat (MAXS) press(1, 0, 0, 0, 8);
        press(0, 1, 0, 0, 8);
        check_state("at99");
        u0 = upd_cnt;
        press(1, 0, 0, 0, 8);
        check("sat_pulses", 32'(upd_cnt - u0), 32'd0);
        check_state("sat");

        // Clear wins over a same-cycle p1 point.
        press(0, 0, 0, 1, 8);
        repeat (3) press(1, 0, 0, 0, 8);
        repeat (4) press(0, 1, 0, 0, 8);
        check_state("at34");
        press(1, 0, 0, 1, 8);
        check_state("clr_p1");
        press(1, 0, 0, 0, 8);

        // Reset mid-debounce of p2 with the button released: no late increment.
        u0 = upd_cnt;
        @(negedge clk);
        p2_btn = 1;
        repeat (3) @(negedge clk);
        rst_n = 0; p2_btn = 0;
        @(negedge clk);
        rst_n = 1;
        m_p1 = 0; m_p2 = 0; m_last = 0;
        exp_q.delete();
        check("midrst_p1", 32'(p1_score), 32'd0);
        check("midrst_upd", 32'(score_upd), 32'd0);
        repeat (20) @(negedge clk);
        check("midrst_pulses", 32'(upd_cnt - u0), 32'd0);
        check_state("midrst");

        // Button held across reset counts exactly once after re-debouncing.
        u0 = upd_cnt;
        @(negedge clk);
        p2_btn = 1;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_apply(0, 1, 0, 0);
        repeat (14) @(negedge clk);
        p2_btn = 0;
        repeat (14) @(negedge clk);
        check("heldrst_pulses", 32'(upd_cnt - u0), 32'd1);
        check_state("heldrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning consecutive stable synchronized cycles needed before a button level is accepted (bench uses 4).
REQ-002 SHALL have parameter MAX_SCORE, default 99, meaning the saturation ceiling per player (two display digits).
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port p1_btn_i, input, 1, raw asynchronous "point for player 1" button, active-high.
REQ-006 SHALL have port p2_btn_i, input, 1, raw asynchronous "point for player 2" button, active-high.
REQ-007 SHALL have port undo_btn_i, input, 1, raw asynchronous "undo last action" button, active-high.
REQ-008 SHALL have port clear_btn_i, input, 1, raw asynchronous "new game" button, active-high.
REQ-009 SHALL have port p1_score_o, output, 8, player 1 score, binary 0..MAX_SCORE, feeding the display controller's p1_score_i.
REQ-010 SHALL have port p2_score_o, output, 8, player 2 score, same rules, feeding p2_score_i.
REQ-011 SHALL have port last_action_o, output, 2, undo history: NONE=0, P1=1, P2=2, BOTH=3.
REQ-012 SHALL have port score_upd_o, output, 1, one-cycle pulse on the cycle after either score register changes.

Function
REQ-013 SHALL pass each raw button through a 2-flop synchronizer, then a debouncer, then a rising-edge detector that produces a 1-cycle event pulse.
REQ-014 SHALL flip the debounced level only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any single-cycle return to the old level restarts the count at 0.
REQ-015 SHALL produce the event pulse DEBOUNCE_CYCLES+3 clock edges after the first edge that samples a stable raw high, and update the score register on the following edge.
REQ-016 SHALL produce exactly one event per debounced press; holding a button SHALL NOT auto-repeat, and a debounced release SHALL produce no event.
REQ-017 SHALL resolve same-cycle events by priority clear > undo > point events; lower-priority events in that cycle SHALL be discarded.
REQ-018 SHALL, on a clear event, set both scores to 0 and last_action_o to NONE.
REQ-019 SHALL, on a point event, add 1 to that player's score if it is below MAX_SCORE; at MAX_SCORE the score is held and is not recorded as an action.
REQ-020 SHALL, when P1 and P2 point events occur in the same cycle, increment both (each subject to REQ-019) and record the action as BOTH if both changed, or as the single player that changed.
REQ-021 SHALL, on an undo event, decrement the score(s) named by last_action_o and then set last_action_o to NONE; undo with NONE SHALL change nothing (one level of history only).
REQ-022 SHALL assert score_upd_o only when a score value actually changes; saturated presses, empty undo and clear at 0:0 SHALL NOT pulse it.
REQ-023 SHALL never let a score wrap: there is no underflow below 0 and no value above MAX_SCORE.

Reset
REQ-024 SHALL, while rst_ni is low at a clock edge, clear the scores, last_action_o (NONE), score_upd_o, the synchronizer flops, the debounce counters, the debounced levels and the edge-detector history, all to 0.
REQ-025 SHALL discard a press whose debounce is in progress when reset arrives; a button still held after reset release SHALL count only after it has been debounced again (one event).

Structure
REQ-026 SHALL take MAX_SCORE default, SCORE_W=8 and the last-action encoding (NONE/P1/P2/BOTH) from shared package scoreboard_pkg.
REQ-027 SHALL instantiate sub-module button_debouncer (synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES) four times; the score/undo logic SHALL stay in score_keeper.

Verification
REQ-028 SHALL cover: p1 press held for 10 cycles, DEBOUNCE_CYCLES=4 -> p1_score_o 0->1 at edge 8 after the press, one score_upd_o pulse, last_action_o=P1.
REQ-029 SHALL cover: p2 press with a 2-cycle glitch, then a 3-cycle clean high, then low -> no score change and no pulse.
REQ-030 SHALL cover: p1 and p2 pressed in the same cycle from 5:7 -> 6:8 and last_action_o=BOTH; then undo -> 5:7 with NONE; a second undo -> no change and no pulse.
REQ-031 SHALL cover: p1 at 99 and pressed -> stays 99 with no pulse, and last_action_o keeps its prior value.
REQ-032 SHALL cover: clear and p1 debounced in the same cycle from 3:4 -> 0:0 and NONE; rst_ni low for 1 cycle mid-debounce of p2 -> all outputs 0 and no late increment.
